// File: rtl/data_mem_ws.sv
// data_mem_ws: a word-organised data memory for the CPU load/store path.
// It has a request/ready handshake and a configurable number of wait states.
// Storage is split into four little-endian byte lanes.
//
// Supported accesses:
//   - byte, half and word stores;
//   - sign- or zero-extended byte/half loads;
//   - word loads.
//
// Parameters:
//   ADDR_W       word-address bits; depth = 2**ADDR_W words per lane
//   WAIT_CYCLES  extra cycles before the memory access (0..15)
//
// Optional build macro:
//   DMEM_MISALIGN_CHK_EN  flag misaligned half/word accesses on mem_err.
//                         Flagged stores are suppressed.
//                         Flagged loads return 0.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   mem_req       access request, sampled only while idle
//   mem_wen       1 = store, 0 = load
//   mem_size      00 byte, 01 half, 10/11 word
//   mem_unsigned  1 = zero-extend loads, 0 = sign-extend
//   mem_addr      byte address
//   mem_data_i    right-aligned store data
//   mem_data_o    load result, held between load completions
//   mem_ready     one-cycle completion pulse
//   mem_busy      high while a request is in flight
//   mem_err       misalignment flag, coincident with mem_ready
module data_mem_ws #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_wen,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ready,
  output logic        mem_busy,
  output logic        mem_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              wen_q, wen_d;
  logic              uns_q, uns_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [7:0]        mem_q [4][DEPTH];

  logic              do_access;
  logic              misalign;
  logic [ADDR_W-1:0] widx;
  logic [1:0]        boff;
  logic [31:0]       rword;
  logic [3:0]        be;
  logic [7:0]        wbyte [4];
  logic [31:0]       ldata;
  logic [7:0]        lbyte;
  logic [15:0]       lhalf;

  // Address bits above the word index wrap modulo depth.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[31:ADDR_W+2];

  assign widx      = addr_q[ADDR_W+1:2];
  assign boff      = addr_q[1:0];
  assign do_access = (state_q == ACC) && (cnt_q == 4'd0);
  assign rword     = {mem_q[3][widx], mem_q[2][widx], mem_q[1][widx], mem_q[0][widx]};

`ifdef DMEM_MISALIGN_CHK_EN
  assign misalign = ((size_q == 2'b01) && boff[0]) ||
                    (size_q[1] && (boff != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Lane enables and per-lane write bytes.
  // Sub-word store data is replicated across lanes so that the enable alone
  // selects the destination.
  always_comb begin
    be = 4'b0000;
    case (size_q)
      2'b00:   be = 4'b0001 << boff;
      2'b01:   be = boff[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    for (int unsigned i = 0; i < 4; i++) begin
      wbyte[i] = wdata_q[8*i +: 8];
      case (size_q)
        2'b00:   wbyte[i] = wdata_q[7:0];
        2'b01:   wbyte[i] = ((i % 2) == 1) ? wdata_q[15:8] : wdata_q[7:0];
        default: wbyte[i] = wdata_q[8*i +: 8];
      endcase
    end
  end

  // Load extraction and extension.
  always_comb begin
    lbyte = rword[{boff, 3'b000} +: 8];
    lhalf = rword[{boff[1], 4'b0000} +: 16];
    ldata = rword;
    case (size_q)
      2'b00:   ldata = uns_q ? {24'd0, lbyte} : {{24{lbyte[7]}}, lbyte};
      2'b01:   ldata = uns_q ? {16'd0, lhalf} : {{16{lhalf[15]}}, lhalf};
      default: ldata = rword;
    endcase
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wen_d     = wen_q;
    uns_d     = uns_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    mem_busy  = 1'b0;
    mem_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          state_d = ACC;
          cnt_d   = 4'(WAIT_CYCLES);
          addr_d  = mem_addr[ADDR_W+1:0];
          size_d  = mem_size;
          wen_d   = mem_wen;
          uns_d   = mem_unsigned;
          wdata_d = mem_data_i;
        end
      end
      ACC: begin
        mem_busy = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          if (!wen_q) begin
            rdata_d = misalign ? '0 : ldata;
          end
        end
      end
      RESP: begin
        mem_busy  = 1'b1;
        mem_ready = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wen_q   <= wen_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is never cleared by reset.
  // A store whose commit edge coincides with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && do_access && wen_q && !misalign) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[i][widx] <= wbyte[i];
        end
      end
    end
  end

  assign mem_data_o = rdata_q;

`ifdef DMEM_MISALIGN_CHK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (do_access) begin
      err_q <= misalign;
    end
  end

  assign mem_err = (state_q == RESP) && err_q;
`else
  assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_ws.sv
module tb_data_mem_ws;

`ifdef DMEM_MISALIGN_CHK_EN
  localparam logic MIS = 1'b1;
`else
  localparam logic MIS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_v = 3'b000;
  logic        wen = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] dout_v [3];
  logic [2:0]  rdy_v, busy_v, err_v;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // u0: default config, u3: three wait states, uw: 16-word depth for wrap.
  data_mem_ws #(.ADDR_W(16), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .mem_req(req_v[0]), .mem_wen(wen), .mem_size(size),
    .mem_unsigned(uns), .mem_addr(addr), .mem_data_i(wdata),
    .mem_data_o(dout_v[0]), .mem_ready(rdy_v[0]), .mem_busy(busy_v[0]),
    .mem_err(err_v[0]));

  data_mem_ws #(.ADDR_W(8), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .mem_req(req_v[1]), .mem_wen(wen), .mem_size(size),
    .mem_unsigned(uns), .mem_addr(addr), .mem_data_i(wdata),
    .mem_data_o(dout_v[1]), .mem_ready(rdy_v[1]), .mem_busy(busy_v[1]),
    .mem_err(err_v[1]));

  data_mem_ws #(.ADDR_W(4), .WAIT_CYCLES(0)) uw (
    .clk(clk), .rst(rst), .mem_req(req_v[2]), .mem_wen(wen), .mem_size(size),
    .mem_unsigned(uns), .mem_addr(addr), .mem_data_i(wdata),
    .mem_data_o(dout_v[2]), .mem_ready(rdy_v[2]), .mem_busy(busy_v[2]),
    .mem_err(err_v[2]));

  typedef struct {
    logic        wen;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issues one request to DUT d in cycle 0 and waits for its ready pulse.
  // Returns at the negedge of the ready cycle; lat = -1 on timeout.
  task automatic xact(input int d, input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] wd,
                      output int lat, output logic [31:0] dout, output logic err);
    @(negedge clk);
    wen = w; size = sz; uns = u; addr = a; wdata = wd;
    req_v[d] = 1'b1;
    @(negedge clk);
    req_v[d] = 1'b0;
    lat = -1; dout = '0; err = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (rdy_v[d] === 1'b1) begin
        lat = k; dout = dout_v[d]; err = err_v[d];
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int          lat;
    logic [31:0] d;
    logic        e;
    int          nrdy;

    tbl[0]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 32'hDEADBEEF, 1'b0};
    tbl[3]  = '{1'b1, 2'b00, 1'b0, 32'h23, 32'h00000080, 32'hDEADBEEF, 1'b0};
    tbl[4]  = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        32'h80223344, 1'b0};
    tbl[5]  = '{1'b0, 2'b00, 1'b0, 32'h23, 32'h0,        32'hFFFFFF80, 1'b0};
    tbl[6]  = '{1'b0, 2'b00, 1'b1, 32'h23, 32'h0,        32'h00000080, 1'b0};
    tbl[7]  = '{1'b1, 2'b01, 1'b0, 32'h22, 32'h0000A5A5, 32'h00000080, 1'b0};
    tbl[8]  = '{1'b0, 2'b01, 1'b0, 32'h22, 32'h0,        32'hFFFFA5A5, 1'b0};
    tbl[9]  = '{1'b0, 2'b01, 1'b1, 32'h20, 32'h0,        32'h00003344, 1'b0};
    tbl[10] = '{1'b0, 2'b00, 1'b0, 32'h21, 32'h0,        32'h00000033, 1'b0};
    tbl[11] = '{1'b0, 2'b11, 1'b0, 32'h20, 32'h0,        32'hA5A53344, 1'b0};
    tbl[12] = '{1'b1, 2'b10, 1'b0, 32'h30, 32'h55667788, 32'hA5A53344, 1'b0};
    tbl[13] = '{1'b1, 2'b10, 1'b0, 32'h31, 32'hCAFEF00D, 32'hA5A53344, MIS};
    tbl[14] = '{1'b0, 2'b10, 1'b0, 32'h32, 32'h0,
                MIS ? 32'h0 : 32'hCAFEF00D, MIS};
    tbl[15] = '{1'b0, 2'b10, 1'b0, 32'h30, 32'h0,
                MIS ? 32'h55667788 : 32'hCAFEF00D, 1'b0};
    tbl[16] = '{1'b0, 2'b01, 1'b0, 32'h21, 32'h0,
                MIS ? 32'h0 : 32'h00003344, MIS};
    tbl[17] = '{1'b1, 2'b00, 1'b0, 32'h22, 32'hFFFFFF7F,
                MIS ? 32'h0 : 32'h00003344, 1'b0};
    tbl[18] = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        32'hA57F3344, 1'b0};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("reset busy",  {31'd0, busy_v[0]}, 32'd0);
    chk("reset ready", {31'd0, rdy_v[0]},  32'd0);
    chk("reset err",   {31'd0, err_v[0]},  32'd0);
    chk("reset data",  dout_v[0],          32'd0);
    rst = 1'b0;

    // Table-driven vectors on the zero-wait-state instance.
    for (int i = 0; i < 19; i++) begin
      xact(0, tbl[i].wen, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd, lat, d, e);
      chk($sformatf("row%0d latency", i), 32'(lat), 32'd2);
      chk($sformatf("row%0d data", i), d, tbl[i].exp_d);
      chk($sformatf("row%0d err", i), {31'd0, e}, {31'd0, tbl[i].exp_e});
    end

    // Three wait states: busy in cycles 1-5, ready only in cycle 5.
    // A request pulse in cycle 3 must be ignored.
    @(negedge clk);
    wen = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h40; wdata = 32'h12345678;
    req_v[1] = 1'b1;
    nrdy = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk($sformatf("ws3 busy c%0d", c), {31'd0, busy_v[1]},
          {31'd0, (c >= 1 && c <= 5)});
      chk($sformatf("ws3 ready c%0d", c), {31'd0, rdy_v[1]}, {31'd0, (c == 5)});
      if (rdy_v[1] === 1'b1) nrdy++;
      req_v[1] = (c == 3);
    end
    chk("ws3 completions", 32'(nrdy), 32'd1);

    xact(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, d, e);
    chk("ws3 load latency", 32'(lat), 32'd5);
    chk("ws3 load data", d, 32'h12345678);

    // Reset mid-ACC drops a pending store.
    @(negedge clk);
    wen = 1'b1; size = 2'b10; addr = 32'h40; wdata = 32'h0BADF00D;
    req_v[1] = 1'b1;
    @(negedge clk);
    req_v[1] = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset busy",  {31'd0, busy_v[1]}, 32'd0);
    chk("midreset ready", {31'd0, rdy_v[1]},  32'd0);
    chk("midreset err",   {31'd0, err_v[1]},  32'd0);
    chk("midreset data",  dout_v[1],          32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("post-reset no ready", {31'd0, rdy_v[1]}, 32'd0);
    xact(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, d, e);
    chk("dropped store latency", 32'(lat), 32'd5);
    chk("dropped store data", d, 32'h12345678);

    // Address wrap with a 16-word memory.
    xact(2, 1'b1, 2'b10, 1'b0, 32'h40, 32'h600DCAFE, lat, d, e);
    chk("wrap store latency", 32'(lat), 32'd2);
    xact(2, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, lat, d, e);
    chk("wrap load data", d, 32'h600DCAFE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
